freq_sweep_ctrl: RTL and testbench
==================================

// Module: freq_sweep_ctrl
// PURPOSE
//  Sequencer for the signal generator's frequency word. Steps freq from f_start
//  to f_stop in f_step increments, holding each value for dwell clocks. Sits
//  between the top level and the generator, replacing the fixed freq register.
//  Supports one-shot, looped, and (optional) triangle sweeps.
// PARAMETERS
//  FW  32  frequency word width, in Hz; must match the generator freq input
//  DW  24  dwell counter width, in clk cycles
// PORTS
//  clk        in   1   system clock (fclk)
//  rst        in   1   reset, asynchronous, active-high
//  start      in   1   1-clk pulse; begins a sweep when idle
//  abort      in   1   1-clk pulse; stops the sweep, freq holds
//  loop       in   1   sampled at start; 1 = repeat the sweep until abort
//  f_start    in   FW  first frequency
//  f_stop     in   FW  last frequency; f_stop < f_start gives a down-sweep
//  f_step     in   FW  step magnitude
//  dwell      in   DW  clocks per frequency value; 0 is treated as 1
//  freq       out  FW  registered frequency word to the generator
//  busy       out  1   high while a sweep is running
//  done       out  1   1-clk pulse when a one-shot sweep completes
//  step_tick  out  1   1-clk pulse on every cycle where freq takes a new value
// BEHAVIOUR
//  - Reset: freq=0, busy=0, done=0, step_tick=0, state=IDLE.
//  - FSM states: IDLE, DWELL, STEP.
//    - IDLE: start -> latch f_start/f_stop/f_step/dwell/loop into shadow regs.
//      Set freq<=f_start, step_tick=1, busy=1, go to DWELL.
//    - DWELL: the counter loads max(dwell,1)-1 on each freq update. Decrement
//      to 0, then go to STEP. Each freq value is held exactly max(dwell,1) cycles.
//    - STEP: runs in the cycle after the counter reaches 0.
//      - If freq != endpoint: freq <= freq +/- step, clamped to the endpoint;
//        step_tick=1; return to DWELL.
//      - If freq == endpoint and loop=1: freq <= f_start, step_tick=1, go to DWELL.
//      - If freq == endpoint and loop=0: done=1, busy=0, go to IDLE; freq holds.
//  - Arithmetic: add/subtract in FW+1 bits, clamp to the endpoint. No overshoot,
//    no wrap. f_stop=2^FW-1 with step 7 ends exactly at 2^FW-1.
//  - Direction is fixed at start: up if f_stop >= f_start, else down.
//  - f_step=0 or f_start=f_stop: a single value, held one dwell, then end (or loop).
//  - Latency: start in cycle N gives freq=f_start and busy=1 in cycle N+1.
//  - Shadow registers: input changes during a sweep are ignored until the next start.
//  - start while busy: ignored.
//  - abort: any state goes to IDLE next cycle, busy=0, no done pulse, freq holds.
//    abort wins over a simultaneous start or step.
//  - Async rst mid-sweep: all outputs return to reset values immediately.
// CONFIGURATION
//  FREQ_SWEEP_TRIANGLE_EN defined:
//    - Reaching f_stop reverses direction instead of ending (f_stop is not
//      re-emitted). The sweep walks back to f_start with the same step, clamped.
//    - The sweep is complete on arrival at f_start after its dwell; loop/done
//      apply there.
//    - A 1-bit dir register is added.
//  FREQ_SWEEP_TRIANGLE_EN undefined:
//    - Sawtooth only, as described above. No dir register.
// TESTING
//  1 Up one-shot: f_start=1000, f_stop=1300, f_step=100, dwell=4.
//    -> freq 1000,1100,1200,1300, each held 4 clks; done pulses once; busy low.
//  2 Clamp and down: f_start=1000, f_stop=750, f_step=100, dwell=1.
//    -> freq 1000,900,800,750, then done; no value below 750.
//  3 Loop and abort: loop=1, 10->30 step 10, dwell=2.
//    -> sequence 10,20,30,10,20,... Abort while freq=20 -> busy=0 next clk,
//       freq stays 20, no done.
//  4 Edges: dwell=0 behaves as dwell=1. f_step=0 -> one value, then done.
//    f_stop=0xFFFFFFFF, f_step=0x80000000, f_start=0xFFFFFFF0 -> ends at 0xFFFFFFFF.
//    start while busy changes nothing.
//  5 Reset: assert rst mid-dwell -> freq=0, busy=0 asynchronously.
//    Simultaneous start+abort while idle -> stays idle.
//  6 TRIANGLE_EN: 0->300 step 100, dwell=1.
//    -> freq 0,100,200,300,200,100,0, then done.

Source files
------------

// File: rtl/freq_sweep_ctrl.sv
// freq_sweep_ctrl
//   Sequencer for the signal generator's frequency word. Steps freq from
//   f_start to f_stop in f_step increments, holding each value for
//   max(dwell,1) clocks. One-shot and looped sawtooth sweeps are always
//   available. Defining FREQ_SWEEP_TRIANGLE_EN turns every sweep into a
//   triangle: out to f_stop, then back to f_start, ending on f_start.
//
//   Parameters
//     FW  frequency word width
//     DW  dwell counter width
//   Ports
//     clk        system clock
//     rst        asynchronous, active-high reset
//     start      1-clk pulse, begins a sweep when idle
//     abort      1-clk pulse, stops the sweep, freq holds
//     loop       sampled at start, repeat the sweep until abort
//     f_start    first frequency
//     f_stop     last (turn-around) frequency; below f_start means down-sweep
//     f_step     step magnitude
//     dwell      clocks per frequency value (0 treated as 1)
//     freq       registered frequency word
//     busy       high while a sweep runs
//     done       1-clk pulse when a one-shot sweep completes
//     step_tick  1-clk pulse on every cycle freq takes a new value
module freq_sweep_ctrl #(
  parameter int unsigned FW = 32,
  parameter int unsigned DW = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          loop,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] freq,
  output logic          busy,
  output logic          done,
  output logic          step_tick
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DWELL,
    S_STEP
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] freq_q, freq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          step_tick_q, step_tick_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] start_sh_q, start_sh_d;
  logic [FW-1:0] stop_sh_q, stop_sh_d;
  logic [FW-1:0] step_sh_q, step_sh_d;
  logic [DW-1:0] dwell_sh_q, dwell_sh_d;
  logic          loop_q, loop_d;
  logic          up_q, up_d;
`ifdef FREQ_SWEEP_TRIANGLE_EN
  logic          dir_q, dir_d;   // 0 = outbound to f_stop, 1 = returning to f_start
  logic [FW-1:0] tgt;
  logic          mv_up;
`endif

  // Counter preload: the STEP cycle is the last cycle of each hold, so a
  // value is held (preload + 1) cycles = max(dwell,1).
  function automatic logic [DW-1:0] dwell_load(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = (d == '0) ? '0 : d - DW'(1);
    return r;
  endfunction

  // One step from cur toward tgt, computed in FW+1 bits and clamped to tgt.
  function automatic logic [FW-1:0] advance(input logic [FW-1:0] cur,
                                            input logic [FW-1:0] stp,
                                            input logic [FW-1:0] tgt_v,
                                            input logic          go_up);
    logic [FW:0]   s;
    logic [FW-1:0] r;
    if (go_up) begin
      s = {1'b0, cur} + {1'b0, stp};
      r = (s >= {1'b0, tgt_v}) ? tgt_v : s[FW-1:0];
    end else begin
      s = {1'b0, cur} - {1'b0, stp};
      r = (s[FW] || (s <= {1'b0, tgt_v})) ? tgt_v : s[FW-1:0];
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    step_tick_d = 1'b0;
    cnt_d       = cnt_q;
    start_sh_d  = start_sh_q;
    stop_sh_d   = stop_sh_q;
    step_sh_d   = step_sh_q;
    dwell_sh_d  = dwell_sh_q;
    loop_d      = loop_q;
    up_d        = up_q;
`ifdef FREQ_SWEEP_TRIANGLE_EN
    dir_d       = dir_q;
    tgt         = dir_q ? start_sh_q : stop_sh_q;
    mv_up       = up_q ^ dir_q;
`endif

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            start_sh_d  = f_start;
            stop_sh_d   = f_stop;
            step_sh_d   = f_step;
            dwell_sh_d  = dwell;
            loop_d      = loop;
            up_d        = (f_stop >= f_start);
            freq_d      = f_start;
            step_tick_d = 1'b1;
            busy_d      = 1'b1;
            cnt_d       = dwell_load(dwell);
            // A one-cycle dwell has no counting phase; go straight to STEP.
            state_d     = (dwell_load(dwell) == '0) ? S_STEP : S_DWELL;
`ifdef FREQ_SWEEP_TRIANGLE_EN
            dir_d       = 1'b0;
`endif
          end
        end

        S_DWELL: begin
          cnt_d = cnt_q - DW'(1);
          if (cnt_q == DW'(1)) state_d = S_STEP;
        end

        S_STEP: begin
          // Default: a new value is emitted and the dwell restarts.
          step_tick_d = 1'b1;
          cnt_d       = dwell_load(dwell_sh_q);
          state_d     = (dwell_load(dwell_sh_q) == '0) ? S_STEP : S_DWELL;
`ifdef FREQ_SWEEP_TRIANGLE_EN
          if ((freq_q != tgt) && (step_sh_q != '0)) begin
            freq_d = advance(freq_q, step_sh_q, tgt, mv_up);
          end else if (!dir_q && (step_sh_q != '0) && (start_sh_q != stop_sh_q)) begin
            // Turn around at f_stop without re-emitting it.
            dir_d  = 1'b1;
            freq_d = advance(freq_q, step_sh_q, start_sh_q, !up_q);
          end else if (loop_q) begin
            dir_d  = 1'b0;
            freq_d = start_sh_q;
          end else begin
            step_tick_d = 1'b0;
            cnt_d       = cnt_q;
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
`else
          if ((freq_q != stop_sh_q) && (step_sh_q != '0)) begin
            freq_d = advance(freq_q, step_sh_q, stop_sh_q, up_q);
          end else if (loop_q) begin
            freq_d = start_sh_q;
          end else begin
            step_tick_d = 1'b0;
            cnt_d       = cnt_q;
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
          end
`endif
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      freq_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_tick_q <= 1'b0;
      cnt_q       <= '0;
      start_sh_q  <= '0;
      stop_sh_q   <= '0;
      step_sh_q   <= '0;
      dwell_sh_q  <= '0;
      loop_q      <= 1'b0;
      up_q        <= 1'b0;
`ifdef FREQ_SWEEP_TRIANGLE_EN
      dir_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_tick_q <= step_tick_d;
      cnt_q       <= cnt_d;
      start_sh_q  <= start_sh_d;
      stop_sh_q   <= stop_sh_d;
      step_sh_q   <= step_sh_d;
      dwell_sh_q  <= dwell_sh_d;
      loop_q      <= loop_d;
      up_q        <= up_d;
`ifdef FREQ_SWEEP_TRIANGLE_EN
      dir_q       <= dir_d;
`endif
    end
  end

  assign freq      = freq_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
module tb_freq_sweep_ctrl;
  localparam int FW = 32;
  localparam int DW = 24;
  typedef logic [FW-1:0] fw_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, loop;
  logic [FW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [FW-1:0] freq;
  logic          busy, done, step_tick;

  freq_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .loop(loop),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .freq(freq), .busy(busy), .done(done), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is the list of values it visits; each is shown for max(dwell,1)
  // cycles, then the next one, then done (or the list restarts when looping).
  fw_t b_seq[$];

  function automatic fw_t toward(input fw_t v, input fw_t s, input fw_t t);
    longint lv, ls, lt;
    lv = v; ls = s; lt = t;
    if (lt >= lv) return ((lt - lv) <= ls) ? t : fw_t'(lv + ls);
    else          return ((lv - lt) <= ls) ? t : fw_t'(lv - ls);
  endfunction

  function automatic void build_seq(input fw_t a, input fw_t b, input fw_t s);
    fw_t v;
    b_seq.delete();
    v = a;
    b_seq.push_back(v);
    if (s != 0) begin
      while (v != b) begin
        v = toward(v, s, b);
        b_seq.push_back(v);
      end
    end
`ifdef FREQ_SWEEP_TRIANGLE_EN
    if (s != 0 && a != b) begin
      while (v != a) begin
        v = toward(v, s, a);
        b_seq.push_back(v);
      end
    end
`endif
  endfunction

  fw_t m_seq[$];
  int  m_idx, m_hold, m_hl;
  bit  m_active, m_loop;
  fw_t m_freq;
  bit  m_busy, m_done, m_tick;

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_freq = '0; m_busy = 0; m_done = 0; m_tick = 0;
    end else begin
      m_done = 0;
      m_tick = 0;
      if (abort) begin
        m_active = 0;
        m_busy   = 0;
      end else if (!m_active) begin
        if (start) begin
          build_seq(f_start, f_stop, f_step);
          m_seq    = b_seq;
          m_hl     = (dwell == 0) ? 1 : int'(dwell);
          m_loop   = loop;
          m_idx    = 0;
          m_hold   = m_hl;
          m_freq   = m_seq[0];
          m_tick   = 1;
          m_busy   = 1;
          m_active = 1;
        end
      end else begin
        m_hold--;
        if (m_hold == 0) begin
          if (m_idx + 1 < m_seq.size()) begin
            m_idx++;
            m_freq = m_seq[m_idx]; m_tick = 1; m_hold = m_hl;
          end else if (m_loop) begin
            m_idx = 0;
            m_freq = m_seq[0]; m_tick = 1; m_hold = m_hl;
          end else begin
            m_active = 0; m_busy = 0; m_done = 1;
          end
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Single compare process, once per cycle away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rst === 1'b0) begin
      chk("freq", 64'(freq), 64'(m_freq));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("step_tick", 64'(step_tick), 64'(m_tick));
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic set_cfg(input fw_t a, input fw_t b, input fw_t s,
                         input logic [DW-1:0] d, input logic l);
    f_start = a; f_stop = b; f_step = s; dwell = d; loop = l;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic run_sweep(input fw_t a, input fw_t b, input fw_t s,
                           input logic [DW-1:0] d);
    set_cfg(a, b, s, d, 1'b0);
    pulse_start();
    wait_idle(500);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    fw_t a, b, s;
    int  n;
    rst = 1'b1; start = 0; abort = 0;
    set_cfg('0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_freq", 64'(freq), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_tick", 64'(step_tick), 64'(0));
    rst = 1'b0;

    // Hand-computed sequences pin the model.
    build_seq(32'd1000, 32'd1300, 32'd100);
    chk("model_up_len", 64'(b_seq.size()), 64'(4));
    chk("model_up_2", 64'(b_seq[2]), 64'(1200));
`ifndef FREQ_SWEEP_TRIANGLE_EN
    chk("model_up_last", 64'(b_seq[3]), 64'(1300));
`endif
    build_seq(32'd1000, 32'd750, 32'd100);
    chk("model_down_3", 64'(b_seq[3]), 64'(750));
    chk("model_down_2", 64'(b_seq[2]), 64'(800));
    build_seq(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h8000_0000);
    chk("model_top_1", 64'(b_seq[1]), 64'(32'hFFFF_FFFF));
    build_seq(32'd0, 32'd300, 32'd100);
`ifdef FREQ_SWEEP_TRIANGLE_EN
    chk("model_tri_len", 64'(b_seq.size()), 64'(7));
    chk("model_tri_4", 64'(b_seq[4]), 64'(200));
    chk("model_tri_6", 64'(b_seq[6]), 64'(0));
`else
    chk("model_saw_len", 64'(b_seq.size()), 64'(4));
`endif

    // Up one-shot, clamp and down
    run_sweep(32'd1000, 32'd1300, 32'd100, 24'd4);
    chk("t1_end_freq", 64'(freq), 64'(1300 * ((`ifdef FREQ_SWEEP_TRIANGLE_EN 0 `else 1 `endif))
                                       + 1000 * ((`ifdef FREQ_SWEEP_TRIANGLE_EN 1 `else 0 `endif))));
    run_sweep(32'd1000, 32'd750, 32'd100, 24'd1);

    // Loop then abort while freq=20
    set_cfg(32'd10, 32'd30, 32'd10, 24'd2, 1'b1);
    pulse_start();
    repeat (8) @(negedge clk);
    n = 0;
    while (freq != 32'd20 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_found_20", 64'(freq), 64'(20));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("t3_abort_busy", 64'(busy), 64'(0));
    chk("t3_abort_freq", 64'(freq), 64'(20));
    chk("t3_abort_done", 64'(done), 64'(0));
    repeat (3) @(negedge clk);

    // Edges
    run_sweep(32'd5, 32'd8, 32'd1, 24'd0);
    run_sweep(32'd50, 32'd90, 32'd0, 24'd3);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h8000_0000, 24'd2);
    chk("t4_top_end", 64'(freq), 64'(`ifdef FREQ_SWEEP_TRIANGLE_EN 32'hFFFF_FFF0 `else 32'hFFFF_FFFF `endif));
    set_cfg(32'd100, 32'd400, 32'd100, 24'd3, 1'b0);
    pulse_start();
    repeat (2) @(negedge clk);
    set_cfg(32'd7, 32'd9, 32'd1, 24'd1, 1'b1);
    pulse_start();
    wait_idle(500);
    repeat (2) @(negedge clk);

    // Async reset mid-dwell, then start+abort while idle
    set_cfg(32'd100, 32'd500, 32'd100, 24'd5, 1'b0);
    pulse_start();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_freq", 64'(freq), 64'(0));
    chk("t5_rst_busy", 64'(busy), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("t5_start_abort_busy", 64'(busy), 64'(0));
    repeat (2) @(negedge clk);

`ifdef FREQ_SWEEP_TRIANGLE_EN
    run_sweep(32'd0, 32'd300, 32'd100, 24'd1);
    chk("t6_tri_end", 64'(freq), 64'(0));
`endif

    // Randomized sweeps with garbage on the inputs while busy
    for (int it = 0; it < 300; it++) begin
      a = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 32'd0 : fw_t'($urandom_range(1, 1000));
      begin
        longint lb;
        longint span;
        span = (s == 0) ? longint'($urandom_range(0, 5000)) : longint'($urandom_range(0, 6000));
        if ($urandom_range(0, 1) == 1) lb = longint'(a) + span;
        else                           lb = longint'(a) - span;
        if (lb > 64'hFFFF_FFFF) lb = 64'hFFFF_FFFF;
        if (lb < 0) lb = 0;
        b = fw_t'(lb);
      end
      set_cfg(a, b, s, DW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0));
      pulse_start();
      for (int c = 0; c < 80 && busy; c++) begin
        @(negedge clk);
        abort   = ($urandom_range(0, 49) == 0);
        start   = busy && ($urandom_range(0, 9) == 0);
        f_start = $urandom; f_stop = $urandom; f_step = $urandom;
        dwell   = DW'($urandom); loop = 1'($urandom);
      end
      @(negedge clk); start = 1'b0; abort = 1'b0;
      if (busy) pulse_abort();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
